fabric_config_sequencer: RTL and testbench

- Front-end controller for the 4-CLB adder fabric.
- Loads an 8-bit configuration word from a byte stream using a framed, checksummed protocol, then holds it on the word that drives the Controller select decode.
- Once configured, accepts operand pairs, drives them into the fabric and waits a fixed fabric latency.
- Captures Sum/Cout and returns the result through a valid/ready handshake.

---
 rtl/fabric_config_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fabric_config_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_sequencer.sv
// Front-end sequencer for the 4-CLB adder fabric: loads a framed, checksummed
// configuration byte, then runs operand pairs through the fabric one at a time.
module fabric_config_sequencer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned FABRIC_LATENCY = 2,
    parameter int unsigned TIMEOUT        = 255,
    parameter logic [7:0]  RESET_BITFILE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_byte,
    output logic       cfg_ready,
    input  logic       op_valid,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       op_ready,
    output logic       res_valid,
    output logic [7:0] res_sum,
    output logic       res_cout,
    input  logic       res_ready,
    output logic [7:0] bitfile_out,
    output logic [7:0] fab_in_1,
    output logic [7:0] fab_in_2,
    input  logic [7:0] fab_sum,
    input  logic       fab_cout,
    output logic       configured,
    output logic       cfg_error,
    output logic       busy,
    output logic [2:0] fsm_state
);

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; ready never depends on the same-cycle transfer itself.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_CHK    = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] shadow;
    logic [7:0] tmo_cnt;
    logic [3:0] lat_cnt;
    logic       cfg_fire;
    logic       op_fire;
    logic       in_frame;
    logic       tmo_hit;
    logic       chk_ok;

    assign in_frame  = (state == S_CFG) || (state == S_CHK);
    // An operand wins over a config byte arriving in the same idle cycle.
    assign cfg_ready = in_frame || ((state == S_IDLE) && !(op_valid && configured));
    assign op_ready  = (state == S_IDLE) && configured;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign op_fire   = op_valid && op_ready;
    assign tmo_hit   = in_frame && !cfg_fire && (tmo_cnt == 8'(TIMEOUT - 1));
    assign chk_ok    = (cfg_byte == (SYNC_BYTE ^ shadow));
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (op_fire) begin
                    state_next = S_EXEC;
                end else if (cfg_fire && (cfg_byte == SYNC_BYTE)) begin
                    state_next = S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_fire) begin
                    state_next = S_CHK;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_CHK: begin
                if (cfg_fire || tmo_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                if (lat_cnt == 4'd0) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow      <= 8'd0;
            tmo_cnt     <= 8'd0;
            lat_cnt     <= 4'd0;
            bitfile_out <= RESET_BITFILE;
            configured  <= 1'b0;
            cfg_error   <= 1'b0;
            fab_in_1    <= 8'd0;
            fab_in_2    <= 8'd0;
            res_valid   <= 1'b0;
            res_sum     <= 8'd0;
            res_cout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (op_fire) begin
                        fab_in_1 <= op_a;
                        fab_in_2 <= op_b;
                        lat_cnt  <= 4'(FABRIC_LATENCY - 1);
                    end
                end
                S_CFG: begin
                    if (cfg_fire) begin
                        shadow  <= cfg_byte;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_hit) begin
                        shadow    <= 8'd0;
                        tmo_cnt   <= 8'd0;
                        cfg_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_CHK: begin
                    if (cfg_fire) begin
                        tmo_cnt <= 8'd0;
                        if (chk_ok) begin
                            bitfile_out <= shadow;
                            configured  <= 1'b1;
                            cfg_error   <= 1'b0;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        shadow    <= 8'd0;
                        tmo_cnt   <= 8'd0;
                        cfg_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    // lat_cnt counts down the cycles still owed to the fabric.
                    if (lat_cnt == 4'd0) begin
                        res_sum   <= fab_sum;
                        res_cout  <= fab_cout;
                        res_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_sequencer.sv
// Directed bench for fabric_config_sequencer with a one-register adder model
// standing in for the fabric (Sum/Cout valid in the second cycle after drive).
module tb_fabric_config_sequencer;

    localparam int unsigned TIMEOUT = 255;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_byte;
    logic       cfg_ready;
    logic       op_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_ready;
    logic       res_valid;
    logic [7:0] res_sum;
    logic       res_cout;
    logic       res_ready;
    logic [7:0] bitfile_out;
    logic [7:0] fab_in_1;
    logic [7:0] fab_in_2;
    logic [7:0] fab_sum;
    logic       fab_cout;
    logic       configured;
    logic       cfg_error;
    logic       busy;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    fabric_config_sequencer #(
        .SYNC_BYTE      (8'hA5),
        .FABRIC_LATENCY (2),
        .TIMEOUT        (TIMEOUT),
        .RESET_BITFILE  (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_byte    (cfg_byte),
        .cfg_ready   (cfg_ready),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_ready    (op_ready),
        .res_valid   (res_valid),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .res_ready   (res_ready),
        .bitfile_out (bitfile_out),
        .fab_in_1    (fab_in_1),
        .fab_in_2    (fab_in_2),
        .fab_sum     (fab_sum),
        .fab_cout    (fab_cout),
        .configured  (configured),
        .cfg_error   (cfg_error),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fabric model: registered adder
    logic [8:0] fab_q = 9'd0;
    always @(posedge clk) fab_q <= {1'b0, fab_in_1} + {1'b0, fab_in_2};
    assign fab_sum  = fab_q[7:0];
    assign fab_cout = fab_q[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drives one byte and returns #1 after the edge that transfers it
    task automatic cfg_send(input logic [7:0] b);
        int waited;
        cfg_byte  = b;
        cfg_valid = 1'b1;
        #1;
        waited = 0;
        while (!cfg_ready && waited < 20) begin
            step();
            waited++;
        end
        check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        step();
    endtask

    initial begin
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_byte  = 8'h00;
        op_valid  = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        res_ready = 1'b0;
        #1;
        step();

        // reset state
        check("rst_bitfile",    {24'd0, bitfile_out}, 32'h00);
        check("rst_configured", {31'd0, configured},  32'd0);
        check("rst_cfg_error",  {31'd0, cfg_error},   32'd0);
        check("rst_res_valid",  {31'd0, res_valid},   32'd0);
        check("rst_busy",       {31'd0, busy},        32'd0);
        check("rst_fab_in_1",   {24'd0, fab_in_1},    32'h00);
        check("rst_op_ready",   {31'd0, op_ready},    32'd0);
        check("rst_cfg_ready",  {31'd0, cfg_ready},   32'd1);
        reset = 1'b1;
        step();

        // good frame A5,3C,99 with cfg_valid held
        cfg_send(8'hA5);
        check("f1_state_cfg", {29'd0, fsm_state}, 32'd1);
        cfg_send(8'h3C);
        check("f1_state_chk", {29'd0, fsm_state}, 32'd2);
        check("f1_bitfile_pre", {24'd0, bitfile_out}, 32'h00);
        cfg_send(8'h99);
        cfg_valid = 1'b0;
        check("f1_bitfile",    {24'd0, bitfile_out}, 32'h3C);
        check("f1_configured", {31'd0, configured},  32'd1);
        check("f1_cfg_error",  {31'd0, cfg_error},   32'd0);
        check("f1_busy",       {31'd0, busy},        32'd0);

        // bad checksum after a fresh reset
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        cfg_send(8'hA5);
        cfg_send(8'h3C);
        cfg_send(8'h98);
        cfg_valid = 1'b0;
        check("f2_cfg_error",  {31'd0, cfg_error},   32'd1);
        check("f2_configured", {31'd0, configured},  32'd0);
        check("f2_bitfile",    {24'd0, bitfile_out}, 32'h00);
        op_valid = 1'b1;
        op_a     = 8'h10;
        op_b     = 8'h20;
        for (int i = 0; i < 3; i++) begin
            check("f2_op_ready", {31'd0, op_ready}, 32'd0);
            step();
            check("f2_busy", {31'd0, busy}, 32'd0);
        end
        op_valid = 1'b0;
        #1;
        check("f2_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // reconfigure; success clears the sticky error
        cfg_send(8'hA5);
        cfg_send(8'h3C);
        cfg_send(8'h99);
        cfg_valid = 1'b0;
        check("f3_bitfile",   {24'd0, bitfile_out}, 32'h3C);
        check("f3_cfg_error", {31'd0, cfg_error},   32'd0);

        // 0x7F + 0x81 with result back-pressure
        op_a     = 8'h7F;
        op_b     = 8'h81;
        op_valid = 1'b1;
        #1;
        check("op1_op_ready", {31'd0, op_ready}, 32'd1);
        step();
        op_valid = 1'b0;
        check("op1_fab_in_1", {24'd0, fab_in_1},  32'h7F);
        check("op1_fab_in_2", {24'd0, fab_in_2},  32'h81);
        check("op1_state",    {29'd0, fsm_state}, 32'd3);
        check("op1_rv_c1",    {31'd0, res_valid}, 32'd0);
        step();
        check("op1_rv_c2", {31'd0, res_valid}, 32'd0);
        step();
        check("op1_rv_c3", {31'd0, res_valid}, 32'd1);
        op_valid = 1'b1;
        op_a     = 8'h01;
        op_b     = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("op1_hold_valid", {31'd0, res_valid}, 32'd1);
            check("op1_hold_sum",   {24'd0, res_sum},   32'h00);
            check("op1_hold_cout",  {31'd0, res_cout},  32'd1);
            check("op1_hold_opr",   {31'd0, op_ready},  32'd0);
            check("op1_hold_fab",   {24'd0, fab_in_1},  32'h7F);
            step();
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("op1_rv_done", {31'd0, res_valid}, 32'd0);
        check("op1_idle",    {31'd0, busy},      32'd0);
        check("op1_keep_fab", {24'd0, fab_in_1}, 32'h7F);

        // operand and sync byte together: operand wins, byte follows later
        op_a      = 8'h05;
        op_b      = 8'h03;
        op_valid  = 1'b1;
        cfg_byte  = 8'hA5;
        cfg_valid = 1'b1;
        #1;
        check("pri_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("pri_op_ready",  {31'd0, op_ready},  32'd1);
        step();
        op_valid = 1'b0;
        check("pri_state_exec", {29'd0, fsm_state}, 32'd3);
        check("pri_exec_cfgr",  {31'd0, cfg_ready}, 32'd0);
        res_ready = 1'b1;
        step();
        step();
        check("pri_res_valid", {31'd0, res_valid}, 32'd1);
        check("pri_res_sum",   {24'd0, res_sum},   32'h08);
        check("pri_res_cout",  {31'd0, res_cout},  32'd0);
        step();
        res_ready = 1'b0;
        check("pri_state_idle", {29'd0, fsm_state}, 32'd0);
        check("pri_rv_low",     {31'd0, res_valid}, 32'd0);
        step();
        check("pri_a5_taken", {29'd0, fsm_state}, 32'd1);

        // timeout after the sync byte
        cfg_valid = 1'b0;
        repeat (TIMEOUT - 1) step();
        check("tmo_still_busy", {31'd0, busy},      32'd1);
        check("tmo_no_err_yet", {31'd0, cfg_error}, 32'd0);
        step();
        check("tmo_busy",      {31'd0, busy},        32'd0);
        check("tmo_cfg_error", {31'd0, cfg_error},   32'd1);
        check("tmo_bitfile",   {24'd0, bitfile_out}, 32'h3C);
        check("tmo_config",    {31'd0, configured},  32'd1);

        cfg_send(8'hA5);
        cfg_send(8'h5A);
        cfg_send(8'hFF);
        cfg_valid = 1'b0;
        check("f4_bitfile",   {24'd0, bitfile_out}, 32'h5A);
        check("f4_cfg_error", {31'd0, cfg_error},   32'd0);

        // asynchronous reset during execution
        op_a     = 8'h11;
        op_b     = 8'h22;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        check("ar_in_exec", {29'd0, fsm_state}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("ar_res_valid",  {31'd0, res_valid},   32'd0);
        check("ar_configured", {31'd0, configured},  32'd0);
        check("ar_bitfile",    {24'd0, bitfile_out}, 32'h00);
        check("ar_busy",       {31'd0, busy},        32'd0);
        check("ar_fab_in_1",   {24'd0, fab_in_1},    32'h00);
        step();
        reset = 1'b1;
        step();
        step();
        check("ar_no_result", {31'd0, res_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
